control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter LOST_FRAMES, default 8: consecutive target-less frames before entering SEARCH; legal range 1..255.
REQ-002 Parameter WDOG_CYCLES, default 6_500_000: clk_in cycles without frame_done_in before entering IDLE; must fit in 24 bits.
REQ-003 Parameter SEARCH_TURN, default 8'h41: DIRECT-mode turn byte used while searching; bits [1:0] are always forced to 2'b01 on output.
REQ-004 clk_in  input  1  system clock; the only clock.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 en_in  input  1  autonomy enable; low forces IDLE.
REQ-007 frame_done_in  input  1  one-cycle pulse at the end of each camera frame.
REQ-008 target_found_in  input  1  target detected in the current frame; sampled only when frame_done_in=1.
REQ-009 user_params_in  input  16  requested params {Ksp[3:0],Ksd[2:0],Ktp[3:0],Ktd[2:0],mode[1:0]}.
REQ-010 user_params_valid_in  input  1  one-cycle strobe that latches user_params_in.
REQ-011 params_out  output  16  params word driven to the speed/turn controller.
REQ-012 ready_out  output  1  one-cycle pulse telling the controller to sample the new position.
REQ-013 state_out  output  2  current state: IDLE=0, TRACK=1, HOLD=2, SEARCH=3.

Function
REQ-014 States are IDLE, TRACK, HOLD and SEARCH; all outputs are registered.
REQ-015 On user_params_valid_in, the shadow register shall load user_params_in; params_out shall change only at a frame boundary (a frame_done_in cycle).
REQ-016 If user_params_valid_in and frame_done_in coincide, the incoming user_params_in value shall be the one applied at that boundary.
REQ-017 On frame_done_in with target_found_in=1:
  - next state is TRACK;
  - lost_cnt clears;
  - params_out takes the shadow value;
  - ready_out pulses high for exactly one cycle on the following cycle.
REQ-018 On frame_done_in with target_found_in=0:
  - lost_cnt increments, saturating at 255;
  - if the new lost_cnt >= LOST_FRAMES, the next state is SEARCH; otherwise it is HOLD;
  - ready_out stays low.
REQ-019 HOLD: params_out keeps its last value.
REQ-020 SEARCH: params_out = {8'h00, SEARCH_TURN[7:2], 2'b01}, which is DIRECT mode with zero speed and a constant spin.
REQ-021 Watchdog counter:
  - clears on every frame_done_in;
  - otherwise increments, saturating;
  - when it reaches WDOG_CYCLES, the next state is IDLE.
REQ-022 IDLE: params_out = 16'h0000 (FORWARD mode, zero output); ready_out = 0.
REQ-023 Exit from IDLE occurs only on frame_done_in, following REQ-017 or REQ-018.
REQ-024 en_in=0: next state is IDLE; lost_cnt and the watchdog counter clear; frame_done_in is ignored. This has priority over REQ-017 to REQ-021.
REQ-025 If the watchdog expires and frame_done_in arrives in the same cycle, the frame event wins and the watchdog counter clears.
REQ-026 ready_out never stays high for 2 consecutive cycles, and never pulses in HOLD, SEARCH or IDLE.

Reset
REQ-027 rst_in=1 at a clock edge shall set:
  - state to IDLE;
  - params_out, the shadow register, lost_cnt and the watchdog counter to 0;
  - ready_out to 0.
REQ-028 Reset mid-frame discards any pending shadow value; the first post-reset TRACK entry applies 16'h0000 unless a new strobe has arrived.

Structure
REQ-029 The state enum, the mode encodings (FORWARD=0, DIRECT=1, CHASE=2, GOALKEEP=3) and the params field widths shall live in the shared package control_pkg.
REQ-030 The watchdog shall be the sub-module frame_watchdog (clk_in, rst_in, clear, timeout pulse); all other logic is flat.

Verification
REQ-031 Reset, then strobe user 16'hA5A6, then frame_done_in with found=1 -> params_out=16'hA5A6 on the next cycle, ready_out one-cycle pulse, state_out=1.
REQ-032 In TRACK, 7 frames with found=0 -> state_out=2 and params_out unchanged; 8th frame -> state_out=3 and params_out=16'h0041; next found=1 frame -> state_out=1 with the shadow value restored.
REQ-033 Strobe 16'h1234 mid-frame in TRACK -> params_out unchanged until the next frame_done_in, then 16'h1234; strobe coinciding with frame_done_in -> that value is applied.
REQ-034 WDOG_CYCLES=100, no frame_done_in for 100 cycles -> state_out=0 and params_out=0; frame_done_in on cycle 100 -> no IDLE entry.
REQ-035 en_in dropped for 1 cycle in SEARCH -> IDLE, lost_cnt cleared; the next found=0 frame -> HOLD, not SEARCH.
REQ-036 rst_in asserted during a ready_out pulse -> ready_out=0 and params_out=0 on the next cycle.

Source files
------------

// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : control_pkg
//  Description : Shared state, mode and params-word definitions for the
//                control sequencer and its frame watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

  localparam int PARAMS_W = 16;
  localparam int KSP_W    = 4;
  localparam int KSD_W    = 3;
  localparam int KTP_W    = 4;
  localparam int KTD_W    = 3;
  localparam int MODE_W   = 2;
  localparam int LOST_W   = 8;
  localparam int WDOG_W   = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SEARCH = 2'd3
  } state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_FORWARD  = 2'd0,
    MODE_DIRECT   = 2'd1,
    MODE_CHASE    = 2'd2,
    MODE_GOALKEEP = 2'd3
  } mode_e;

  // Field order matches the wire format {Ksp, Ksd, Ktp, Ktd, mode}.
  typedef struct packed {
    logic [KSP_W-1:0] ksp;
    logic [KSD_W-1:0] ksd;
    logic [KTP_W-1:0] ktp;
    logic [KTD_W-1:0] ktd;
    mode_e            mode;
  } params_t;

  localparam params_t PARAMS_ZERO = '0;

endpackage : control_pkg
`default_nettype wire

// File: rtl/frame_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : frame_watchdog
//  Description : Counts cycles since the last clear; pulses timeout_out on the
//                WDOG_CYCLES-th consecutive uncleared cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_watchdog
  import control_pkg::*;
#(
  parameter int WDOG_CYCLES = 6_500_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic timeout_out
);

  localparam logic [WDOG_W-1:0] COUNT_LIMIT = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] COUNT_LAST  = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] count_d;
  logic [WDOG_W-1:0] count_q;

  // Saturating at the limit keeps the timeout a single pulse per silence.
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (count_q != COUNT_LIMIT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_out = !clear_in && (count_q == COUNT_LAST);

endmodule : frame_watchdog
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Frame-driven IDLE/TRACK/HOLD/SEARCH sequencer that applies
//                user params at frame boundaries and supervises frame arrival.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
  import control_pkg::*;
#(
  parameter int         LOST_FRAMES = 8,
  parameter int         WDOG_CYCLES = 6_500_000,
  parameter logic [7:0] SEARCH_TURN = 8'h41
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en_in,
  input  logic                frame_done_in,
  input  logic                target_found_in,
  input  logic [PARAMS_W-1:0] user_params_in,
  input  logic                user_params_valid_in,
  output logic [PARAMS_W-1:0] params_out,
  output logic                ready_out,
  output logic [1:0]          state_out
);

  localparam logic [LOST_W-1:0] LOST_THRESH = LOST_W'(LOST_FRAMES);
  localparam logic [LOST_W-1:0] LOST_MAX    = '1;
  localparam params_t SEARCH_PARAMS = params_t'({8'h00, SEARCH_TURN[7:2], MODE_DIRECT});

  state_e            state_d,  state_q;
  params_t           params_d, params_q;
  params_t           shadow_d, shadow_q;
  logic              ready_d,  ready_q;
  logic [LOST_W-1:0] lost_d,   lost_q;
  logic [LOST_W-1:0] lost_inc;
  logic              wdog_clear;
  logic              wdog_timeout;

  assign wdog_clear = frame_done_in || !en_in;

  frame_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_frame_watchdog (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (wdog_clear),
    .timeout_out (wdog_timeout)
  );

  assign lost_inc = (lost_q == LOST_MAX) ? lost_q : lost_q + 1'b1;

  // shadow_d already reflects a coincident strobe, so using it at the frame
  // boundary applies the freshly arrived value.
  always_comb begin
    shadow_d = user_params_valid_in ? params_t'(user_params_in) : shadow_q;
    state_d  = state_q;
    params_d = params_q;
    lost_d   = lost_q;
    ready_d  = 1'b0;

    if (!en_in) begin
      state_d  = ST_IDLE;
      params_d = PARAMS_ZERO;
      lost_d   = '0;
    end else if (frame_done_in) begin
      if (target_found_in) begin
        state_d  = ST_TRACK;
        params_d = shadow_d;
        lost_d   = '0;
        ready_d  = 1'b1;
      end else begin
        lost_d = lost_inc;
        if (lost_inc >= LOST_THRESH) begin
          state_d  = ST_SEARCH;
          params_d = SEARCH_PARAMS;
        end else begin
          state_d  = ST_HOLD;
        end
      end
    end else if (wdog_timeout) begin
      state_d  = ST_IDLE;
      params_d = PARAMS_ZERO;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      params_q <= PARAMS_ZERO;
      shadow_q <= PARAMS_ZERO;
      ready_q  <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      params_q <= params_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
    end
  end

  assign params_out = params_q;
  assign ready_out  = ready_q;
  assign state_out  = state_q;

endmodule : control_sequencer
`default_nettype wire
